// File: rtl/reg_wr_arbiter.sv
// Write-port arbiter for the register bank. It picks one of the writeback and memory-load
// requesters each cycle and turns the winner into a registered one-hot load strobe plus data.
module reg_wr_arbiter #(
  parameter int NREG     = 8,
  parameter int AW       = 3,
  parameter int W        = 16,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            freeze,
  input  logic            wb_req,
  input  logic [AW-1:0]   wb_addr,
  input  logic [W-1:0]    wb_data,
  output logic            wb_gnt,
  input  logic            mem_req,
  input  logic [AW-1:0]   mem_addr,
  input  logic [W-1:0]    mem_data,
  output logic            mem_gnt,
  output logic [NREG-1:0] ld_str,
  output logic [W-1:0]    wr_data,
  output logic            collide
);

  localparam logic LAST_WB  = 1'b0;
  localparam logic LAST_MEM = 1'b1;
  localparam logic ZR_EN    = (ZERO_REG != 0);

  function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] a);
    logic [NREG-1:0] v;
    v    = {NREG{1'b0}};
    v[a] = 1'b1;
    return v;
  endfunction

  logic            last_q, last_d;
  logic [NREG-1:0] ld_str_q, ld_str_d;
  logic [W-1:0]    wr_data_q, wr_data_d;
  logic            collide_q, collide_d;
  logic            active_s, wb_gnt_s, mem_gnt_s, wr_en_s;
  logic [AW-1:0]   sel_addr_s;

  // Grant decision: the requester not served last wins a tie; reset and freeze block all grants.
  always_comb begin
    active_s  = clr_n & ~freeze;
    wb_gnt_s  = active_s & wb_req  & (~mem_req | (last_q == LAST_MEM));
    mem_gnt_s = active_s & mem_req & (~wb_req  | (last_q == LAST_WB));
  end

  // Next-state for round-robin pointer, strobe, data and collision flag.
  always_comb begin
    last_d     = last_q;
    wr_data_d  = wr_data_q;
    sel_addr_s = {AW{1'b0}};
    wr_en_s    = 1'b0;
    if (wb_gnt_s) begin
      last_d     = LAST_WB;
      wr_data_d  = wb_data;
      sel_addr_s = wb_addr;
      wr_en_s    = 1'b1;
    end else if (mem_gnt_s) begin
      last_d     = LAST_MEM;
      wr_data_d  = mem_data;
      sel_addr_s = mem_addr;
      wr_en_s    = 1'b1;
    end else begin
      last_d     = last_q;
      wr_data_d  = wr_data_q;
    end
    // A write to the hardwired zero register completes but must not strobe any slice.
    if (wr_en_s && !(ZR_EN && (sel_addr_s == {AW{1'b0}}))) begin
      ld_str_d = onehot(sel_addr_s);
    end else begin
      ld_str_d = {NREG{1'b0}};
    end
    collide_d = ~freeze & wb_req & mem_req & (wb_addr == mem_addr);
  end

  // State registers; reset clears any pending strobe immediately.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      last_q    <= LAST_MEM;
      ld_str_q  <= {NREG{1'b0}};
      wr_data_q <= {W{1'b0}};
      collide_q <= 1'b0;
    end else begin
      last_q    <= last_d;
      ld_str_q  <= ld_str_d;
      wr_data_q <= wr_data_d;
      collide_q <= collide_d;
    end
  end

  assign wb_gnt  = wb_gnt_s;
  assign mem_gnt = mem_gnt_s;
  assign ld_str  = ld_str_q;
  assign wr_data = wr_data_q;
  assign collide = collide_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed bench for reg_wr_arbiter: grants are checked in the request cycle, registered
// outputs are queued as expectations and checked by an independent monitor one edge later.
module tb_reg_wr_arbiter;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        freeze = 1'b0;
  logic        wb_req = 1'b0, mem_req = 1'b0;
  logic [2:0]  wb_addr = 3'd0, mem_addr = 3'd0;
  logic [15:0] wb_data = 16'h0, mem_data = 16'h0;
  logic        wb_gnt, mem_gnt, collide;
  logic [7:0]  ld_str;
  logic [15:0] wr_data;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0]  ld;
    logic [15:0] wd;
    logic        col;
    string       tag;
  } exp_t;
  exp_t exp_q[$];

  reg_wr_arbiter #(.NREG(8), .AW(3), .W(16), .ZERO_REG(1)) dut (
    .clk(clk), .clr_n(clr_n), .freeze(freeze),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_gnt(wb_gnt),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_gnt(mem_gnt),
    .ld_str(ld_str), .wr_data(wr_data), .collide(collide)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request cycle: drive at negedge, check grants, queue the registered response.
  task automatic cyc(input string tag, input logic frz,
                     input logic wr, input logic [2:0] wa, input logic [15:0] wd,
                     input logic mr, input logic [2:0] ma, input logic [15:0] md,
                     input logic ewg, input logic emg,
                     input logic [7:0] eld, input logic [15:0] ewd, input logic ecol);
    exp_t e;
    @(negedge clk);
    freeze = frz; wb_req = wr; wb_addr = wa; wb_data = wd;
    mem_req = mr; mem_addr = ma; mem_data = md;
    #1;
    chk({tag, ".wb_gnt"}, {31'd0, wb_gnt}, {31'd0, ewg});
    chk({tag, ".mem_gnt"}, {31'd0, mem_gnt}, {31'd0, emg});
    e.ld = eld; e.wd = ewd; e.col = ecol; e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  // Assert reset shortly after an edge, check outputs clear at once, release at a negedge.
  task automatic do_reset(input string tag);
    #2;
    clr_n = 1'b0;
    #1;
    chk({tag, ".rst_ld_str"}, {24'd0, ld_str}, 32'd0);
    chk({tag, ".rst_wr_data"}, {16'd0, wr_data}, 32'd0);
    chk({tag, ".rst_collide"}, {31'd0, collide}, 32'd0);
    chk({tag, ".rst_gnt"}, {30'd0, wb_gnt, mem_gnt}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    wb_req = 1'b0; mem_req = 1'b0; freeze = 1'b0;
    clr_n = 1'b1;
  endtask

  // Monitor: registered outputs are compared just after every rising edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.tag, ".ld_str"}, {24'd0, ld_str}, {24'd0, e.ld});
      chk({e.tag, ".wr_data"}, {16'd0, wr_data}, {16'd0, e.wd});
      chk({e.tag, ".collide"}, {31'd0, collide}, {31'd0, e.col});
    end
  end

  initial begin
    wb_req = 1'b1;
    do_reset("init");

    cyc("single_wb", 1'b0, 1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0, 16'h0,
        1'b1, 1'b0, 8'h20, 16'hBEEF, 1'b0);

    do_reset("rr_pre");
    cyc("rr0", 1'b0, 1'b1, 3'd2, 16'h1111, 1'b1, 3'd3, 16'h2222, 1'b1, 1'b0, 8'h04, 16'h1111, 1'b0);
    cyc("rr1", 1'b0, 1'b1, 3'd2, 16'h1111, 1'b1, 3'd3, 16'h2222, 1'b0, 1'b1, 8'h08, 16'h2222, 1'b0);
    cyc("rr2", 1'b0, 1'b1, 3'd2, 16'h1111, 1'b1, 3'd3, 16'h2222, 1'b1, 1'b0, 8'h04, 16'h1111, 1'b0);
    cyc("rr3", 1'b0, 1'b1, 3'd2, 16'h1111, 1'b1, 3'd3, 16'h2222, 1'b0, 1'b1, 8'h08, 16'h2222, 1'b0);

    cyc("coll0", 1'b0, 1'b1, 3'd6, 16'hAAAA, 1'b1, 3'd6, 16'h5555, 1'b1, 1'b0, 8'h40, 16'hAAAA, 1'b1);
    cyc("coll1", 1'b0, 1'b0, 3'd6, 16'hAAAA, 1'b1, 3'd6, 16'h5555, 1'b0, 1'b1, 8'h40, 16'h5555, 1'b0);

    cyc("zero_reg", 1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 16'h1234, 1'b0, 1'b1, 8'h00, 16'h1234, 1'b0);

    for (int i = 0; i < 3; i++) begin
      cyc("frz", 1'b1, 1'b1, 3'd7, 16'h0101, 1'b1, 3'd7, 16'h0707, 1'b0, 1'b0, 8'h00, 16'h1234, 1'b0);
    end
    cyc("unfrz0", 1'b0, 1'b1, 3'd7, 16'h0101, 1'b1, 3'd7, 16'h0707, 1'b1, 1'b0, 8'h80, 16'h0101, 1'b1);
    cyc("unfrz1", 1'b0, 1'b0, 3'd7, 16'h0101, 1'b1, 3'd7, 16'h0707, 1'b0, 1'b1, 8'h80, 16'h0707, 1'b0);

    cyc("pre_rst", 1'b0, 1'b1, 3'd4, 16'h4444, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 8'h10, 16'h4444, 1'b0);
    wb_req = 1'b1;
    do_reset("mid_rst");
    cyc("tie0", 1'b0, 1'b1, 3'd1, 16'h0A0A, 1'b1, 3'd2, 16'h0B0B, 1'b1, 1'b0, 8'h02, 16'h0A0A, 1'b0);
    cyc("tie1", 1'b0, 1'b0, 3'd1, 16'h0A0A, 1'b1, 3'd2, 16'h0B0B, 1'b0, 1'b1, 8'h04, 16'h0B0B, 1'b0);
    cyc("idle", 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0B0B, 1'b0);

    @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
